sd_xfer_sched: RTL and testbench
================================

Name: sd_xfer_sched

Overview:
- Transaction sequencer for the SD host. Takes the start flag and the command/transfer registers, then orders the CMD issue, the DAT-line transfer and the ADMA/FIFO movement.
- Counts blocks, honours stop-at-block-gap, optionally issues Auto CMD12, and produces the PSR inhibit bits and the NISR/EISR event pulses.
- Sits beside start_detect in the sd_host top, on the host CLK domain.

Parameters:
- BLK_CNT_W, 16, width of block counter (matches Block_Count_Register)
- CMD12_IDX, 12, command index driven for the Auto CMD12 stop command

Ports:
- CLK  in  1  host clock
- rst_L  in  1  asynchronous active-low reset
- start_flag  in  1  one-cycle pulse from start_detect (Command_Register written)
- cmd_index_in  in  6  Command_Register[13:8]
- data_present  in  1  Command_Register[5]
- multi_blk  in  1  Transfer_Mode_Register[5]
- blk_cnt_en  in  1  Transfer_Mode_Register[1]
- auto_cmd12  in  1  Transfer_Mode_Register[2]
- dir_read  in  1  Transfer_Mode_Register[4]; 1 = card to host
- block_count  in  BLK_CNT_W  Block_Count_Register
- stop_at_gap  in  1  BGCR[0]
- continue_req  in  1  BGCR[1], level
- cmd_done  in  1  pulse: response received from CMD path
- cmd_err  in  1  pulse: CMD timeout/CRC/index error
- dat_blk_done  in  1  pulse: one block finished on DAT lines
- dat_err  in  1  pulse: DAT CRC/timeout error
- dma_err  in  1  pulse: ADMA error (EISR source)
- cmd_start  out  1  pulse: launch command
- cmd_index_out  out  6  index for current command
- dat_start  out  1  pulse: launch one block on DAT
- dat_dir  out  1  latched dir_read
- dma_start  out  1  pulse: enable ADMA descriptor fetch
- cmd_inhibit  out  1  PSR[0]
- dat_inhibit  out  1  PSR[1]
- blk_remaining  out  BLK_CNT_W  live block counter
- cmd_complete  out  1  NISR[0] pulse
- xfer_complete  out  1  NISR[1] pulse
- gap_event  out  1  NISR[2] pulse
- err_int  out  1  NISR[15] pulse
- err_src  out  3  latched {dma,dat,cmd} error cause

Behaviour:
- Reset (async on rst_L low, including mid-transfer):
  - State goes to IDLE.
  - All outputs go to 0, including err_src and blk_remaining.
  - Pending events are dropped.
- Transfer parameters are captured in IDLE on start_flag: index, data_present, multi_blk, blk_cnt_en, auto_cmd12, dir_read, block_count.
  - start_flag outside IDLE is ignored.
  - err_src clears on an accepted start_flag.
- cmd_inhibit = 1 in every state except IDLE, XFER and GAP.
- dat_inhibit = 1 from accept (when data_present) until return to IDLE.
- States:
  - IDLE: on start_flag -> ISSUE (next cycle).
  - ISSUE:
    - cmd_start=1 for exactly one cycle; cmd_index_out=captured index.
    - -> WAIT_RSP.
  - WAIT_RSP:
    - cmd_err -> ERR.
    - cmd_done -> pulse cmd_complete. Then:
      - -> LOAD if data_present.
      - -> DONE if no data_present.
  - LOAD:
    - blk_remaining = 1 if !multi_blk.
    - blk_remaining = block_count if multi_blk&blk_cnt_en.
    - blk_remaining = all-ones if multi_blk&!blk_cnt_en (infinite).
    - If the loaded count is 0 -> DONE with no data pulses.
    - Otherwise pulse dat_start and dma_start together -> XFER.
  - XFER, on dat_blk_done:
    - Decrement blk_remaining; the infinite case does not decrement.
    - New count 0 -> C12 if auto_cmd12&multi_blk (with `SD_AUTO_CMD12_EN`); otherwise -> DONE.
    - Else if stop_at_gap -> GAP, pulse gap_event.
    - Else pulse dat_start the next cycle and stay in XFER.
  - GAP: when continue_req=1 and stop_at_gap=0 -> pulse dat_start -> XFER.
  - C12:
    - cmd_start pulse; cmd_index_out=CMD12_IDX.
    - -> W12, which waits for cmd_done -> DONE or cmd_err -> ERR.
  - DONE: pulse xfer_complete if data_present, else nothing -> IDLE.
  - ERR:
    - Latch err_src bit(s); pulse err_int.
    - -> IDLE; dat_inhibit drops the same cycle.
- Simultaneous events:
  - Error beats done; dat_err or dma_err in XFER/GAP -> ERR.
  - cmd_err and cmd_done in the same cycle -> ERR.
  - Multiple error pulses in one cycle set multiple err_src bits.
- Latency:
  - start_flag to cmd_start: 1 cycle.
  - cmd_done to dat_start: 2 cycles (WAIT_RSP -> LOAD -> pulse).
  - dat_blk_done to next dat_start: 1 cycle.
- Counter arithmetic is unsigned BLK_CNT_W and never wraps; the decrement is gated at 0.

Optional Feature:
- Macro `SD_AUTO_CMD12_EN`.
- Defined: states C12/W12 exist; the auto_cmd12 input is honoured.
- Undefined:
  - auto_cmd12 is ignored.
  - The final block goes XFER -> DONE.
  - cmd_index_out only ever carries the captured index.

Decomposition:
- State encodings (4-bit), NISR/PSR bit positions, err_src bit order and the CMD12 index default go in defines.v.
- One sub-module, sd_blk_counter: load/decrement/zero-detect/infinite-mode counter.

Test Plan:
- Non-data command: start_flag, index 8, data_present=0, cmd_done after 10 cycles -> cmd_start at +1 with index 8; cmd_complete; no dat_start; inhibits low; IDLE.
- Single-block read: data_present=1, multi_blk=0, cmd_done then dat_blk_done -> dat_start and dma_start 2 cycles after cmd_done; dat_dir=1; xfer_complete one cycle after dat_blk_done.
- Multi-block with Auto CMD12, macro on:
  - Stimulus: block_count=3, auto_cmd12=1.
  - Response: 3 dat_start pulses; blk_remaining 3->2->1->0; cmd_start with index 12; xfer_complete after its cmd_done.
  - Same run with the macro off: no second cmd_start.
- Block gap: block_count=4, stop_at_gap=1 after block 2 -> gap_event, no dat_start until continue_req=1; then resume and finish at count 0.
- Errors:
  - dat_err coincident with final dat_blk_done -> err_int, err_src=3'b010, no xfer_complete.
  - cmd_err+cmd_done together -> err_src=3'b001.
- Reset mid-XFER (rst_L low asynchronously) -> all outputs 0 immediately; a later start_flag runs cleanly; block_count=0 multi/cnt_en -> immediate DONE with no dat_start.

Source files
------------

// File: rtl/sd_xfer_sched_pkg.sv
// Shared state encoding and constants for the SD transfer scheduler.
// Auto CMD12 support in the top is selected with the SD_AUTO_CMD12_EN macro.
package sd_xfer_sched_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StIssue   = 4'd1,
    StWaitRsp = 4'd2,
    StLoad    = 4'd3,
    StXfer    = 4'd4,
    StGap     = 4'd5,
    StC12     = 4'd6,
    StW12     = 4'd7,
    StDone    = 4'd8,
    StErr     = 4'd9
  } state_e;

  // err_src bit order: {dma, dat, cmd}
  localparam int unsigned ErrCmdBit = 0;
  localparam int unsigned ErrDatBit = 1;
  localparam int unsigned ErrDmaBit = 2;

  localparam logic [5:0] Cmd12IdxDefault = 6'd12;

endpackage

// File: rtl/sd_blk_counter.sv
// Block counter: clear, load, gated decrement and last-block detect.
// In infinite mode the loaded value is held and the last flag never asserts.
module sd_blk_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         load_inf,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] count_q, count_d;
  logic         inf_q, inf_d;

  always_comb begin
    count_d = count_q;
    inf_d   = inf_q;
    if (clear) begin
      count_d = '0;
      inf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
      inf_d   = load_inf;
    end else if (dec && !inf_q && (count_q != '0)) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      inf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      inf_q   <= inf_d;
    end
  end

  assign count = count_q;
  // True when one more completed block brings the count to zero.
  assign last  = !inf_q && (count_q <= One);

endmodule

// File: rtl/sd_xfer_sched.sv
// SD host transaction sequencer: CMD issue, DAT block loop, block gap, errors.
// Define SD_AUTO_CMD12_EN to add the Auto CMD12 stop-command states.
module sd_xfer_sched
  import sd_xfer_sched_pkg::*;
#(
  parameter int unsigned BLK_CNT_W = 16,
  parameter logic [5:0]  CMD12_IDX = Cmd12IdxDefault
) (
  input  logic                 CLK,
  input  logic                 rst_L,
  input  logic                 start_flag,
  input  logic [5:0]           cmd_index_in,
  input  logic                 data_present,
  input  logic                 multi_blk,
  input  logic                 blk_cnt_en,
  input  logic                 auto_cmd12,
  input  logic                 dir_read,
  input  logic [BLK_CNT_W-1:0] block_count,
  input  logic                 stop_at_gap,
  input  logic                 continue_req,
  input  logic                 cmd_done,
  input  logic                 cmd_err,
  input  logic                 dat_blk_done,
  input  logic                 dat_err,
  input  logic                 dma_err,
  output logic                 cmd_start,
  output logic [5:0]           cmd_index_out,
  output logic                 dat_start,
  output logic                 dat_dir,
  output logic                 dma_start,
  output logic                 cmd_inhibit,
  output logic                 dat_inhibit,
  output logic [BLK_CNT_W-1:0] blk_remaining,
  output logic                 cmd_complete,
  output logic                 xfer_complete,
  output logic                 gap_event,
  output logic                 err_int,
  output logic [2:0]           err_src
);

  localparam logic [BLK_CNT_W-1:0] BlkOne = BLK_CNT_W'(1);

  state_e state_q, state_d;

  logic [5:0]           idx_q;
  logic                 dp_q, multi_q, cnt_en_q, dir_q;
  logic [BLK_CNT_W-1:0] bc_q;
  logic [2:0]           err_src_q, err_src_d;
  logic                 cmd_complete_q, cmd_complete_d;
  logic                 gap_event_q, gap_event_d;
  logic                 dat_start_q, dat_start_d;
  logic                 dma_start_q, dma_start_d;

  logic                 capture, cnt_clear, cnt_load, cnt_dec, cnt_last, use_c12;
  logic [BLK_CNT_W-1:0] load_val, cnt_value;
  logic [2:0]           err_now;

`ifdef SD_AUTO_CMD12_EN
  logic ac12_q;

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      ac12_q <= 1'b0;
    end else if (capture) begin
      ac12_q <= auto_cmd12;
    end
  end

  assign use_c12       = ac12_q & multi_q;
  assign cmd_index_out = ((state_q == StC12) || (state_q == StW12)) ? CMD12_IDX : idx_q;
`else
  logic       unused_ac12;
  logic [5:0] unused_cmd12_idx;

  assign unused_ac12      = auto_cmd12;
  assign unused_cmd12_idx = CMD12_IDX;
  assign use_c12          = 1'b0;
  assign cmd_index_out    = idx_q;
`endif

  always_comb begin
    err_now            = '0;
    err_now[ErrCmdBit] = cmd_err;
    err_now[ErrDatBit] = dat_err;
    err_now[ErrDmaBit] = dma_err;
  end

  always_comb begin
    if (!multi_q) begin
      load_val = BlkOne;
    end else if (cnt_en_q) begin
      load_val = bc_q;
    end else begin
      load_val = '1;
    end
  end

  always_comb begin
    state_d        = state_q;
    err_src_d      = err_src_q;
    cmd_complete_d = 1'b0;
    gap_event_d    = 1'b0;
    dat_start_d    = 1'b0;
    dma_start_d    = 1'b0;
    capture        = 1'b0;
    cnt_clear      = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_flag) begin
          capture   = 1'b1;
          cnt_clear = 1'b1;
          err_src_d = '0;
          state_d   = StIssue;
        end
      end
      StIssue: state_d = StWaitRsp;
      StWaitRsp: begin
        if (cmd_err) begin
          err_src_d = err_now;
          state_d   = StErr;
        end else if (cmd_done) begin
          cmd_complete_d = 1'b1;
          state_d        = dp_q ? StLoad : StDone;
        end
      end
      StLoad: begin
        cnt_load = 1'b1;
        if (load_val == '0) begin
          state_d = StDone;
        end else begin
          dat_start_d = 1'b1;
          dma_start_d = 1'b1;
          state_d     = StXfer;
        end
      end
      StXfer: begin
        if (dat_err || dma_err) begin
          err_src_d = err_now;
          state_d   = StErr;
        end else if (dat_blk_done) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = use_c12 ? StC12 : StDone;
          end else if (stop_at_gap) begin
            gap_event_d = 1'b1;
            state_d     = StGap;
          end else begin
            dat_start_d = 1'b1;
          end
        end
      end
      StGap: begin
        if (dat_err || dma_err) begin
          err_src_d = err_now;
          state_d   = StErr;
        end else if (continue_req && !stop_at_gap) begin
          dat_start_d = 1'b1;
          state_d     = StXfer;
        end
      end
      StC12: state_d = StW12;
      StW12: begin
        if (cmd_err) begin
          err_src_d = err_now;
          state_d   = StErr;
        end else if (cmd_done) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      dp_q           <= 1'b0;
      multi_q        <= 1'b0;
      cnt_en_q       <= 1'b0;
      dir_q          <= 1'b0;
      bc_q           <= '0;
      err_src_q      <= '0;
      cmd_complete_q <= 1'b0;
      gap_event_q    <= 1'b0;
      dat_start_q    <= 1'b0;
      dma_start_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_src_q      <= err_src_d;
      cmd_complete_q <= cmd_complete_d;
      gap_event_q    <= gap_event_d;
      dat_start_q    <= dat_start_d;
      dma_start_q    <= dma_start_d;
      if (capture) begin
        idx_q    <= cmd_index_in;
        dp_q     <= data_present;
        multi_q  <= multi_blk;
        cnt_en_q <= blk_cnt_en;
        dir_q    <= dir_read;
        bc_q     <= block_count;
      end
    end
  end

  sd_blk_counter #(
    .W (BLK_CNT_W)
  ) u_blk_counter (
    .clk      (CLK),
    .rst_n    (rst_L),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (load_val),
    .load_inf (multi_q & ~cnt_en_q),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .last     (cnt_last)
  );

  assign cmd_start     = (state_q == StIssue) || (state_q == StC12);
  assign dat_start     = dat_start_q;
  assign dma_start     = dma_start_q;
  assign dat_dir       = dir_q;
  assign cmd_inhibit   = !((state_q == StIdle) || (state_q == StXfer) || (state_q == StGap));
  assign dat_inhibit   = dp_q && (state_q != StIdle) && (state_q != StErr);
  assign blk_remaining = cnt_value;
  assign cmd_complete  = cmd_complete_q;
  assign xfer_complete = (state_q == StDone) && dp_q;
  assign gap_event     = gap_event_q;
  assign err_int       = (state_q == StErr);
  assign err_src       = err_src_q;

endmodule

// File: tb/tb_sd_xfer_sched.sv
// Scoreboard bench for sd_xfer_sched: scripted stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT pulses an event output.
module tb_sd_xfer_sched;

  localparam logic [6:0] EvCs  = 7'b0000001;
  localparam logic [6:0] EvDs  = 7'b0000010;
  localparam logic [6:0] EvDma = 7'b0000100;
  localparam logic [6:0] EvCc  = 7'b0001000;
  localparam logic [6:0] EvXc  = 7'b0010000;
  localparam logic [6:0] EvGap = 7'b0100000;
  localparam logic [6:0] EvErr = 7'b1000000;

  logic        CLK = 1'b0;
  logic        rst_L = 1'b0;
  logic        start_flag = 1'b0;
  logic [5:0]  cmd_index_in = '0;
  logic        data_present = 1'b0, multi_blk = 1'b0, blk_cnt_en = 1'b0;
  logic        auto_cmd12 = 1'b0, dir_read = 1'b0;
  logic [15:0] block_count = '0;
  logic        stop_at_gap = 1'b0, continue_req = 1'b0;
  logic        cmd_done = 1'b0, cmd_err = 1'b0, dat_blk_done = 1'b0;
  logic        dat_err = 1'b0, dma_err = 1'b0;

  logic        cmd_start, dat_start, dat_dir, dma_start, cmd_inhibit, dat_inhibit;
  logic [5:0]  cmd_index_out;
  logic [15:0] blk_remaining;
  logic        cmd_complete, xfer_complete, gap_event, err_int;
  logic [2:0]  err_src;

  sd_xfer_sched dut (
    .CLK           (CLK),
    .rst_L         (rst_L),
    .start_flag    (start_flag),
    .cmd_index_in  (cmd_index_in),
    .data_present  (data_present),
    .multi_blk     (multi_blk),
    .blk_cnt_en    (blk_cnt_en),
    .auto_cmd12    (auto_cmd12),
    .dir_read      (dir_read),
    .block_count   (block_count),
    .stop_at_gap   (stop_at_gap),
    .continue_req  (continue_req),
    .cmd_done      (cmd_done),
    .cmd_err       (cmd_err),
    .dat_blk_done  (dat_blk_done),
    .dat_err       (dat_err),
    .dma_err       (dma_err),
    .cmd_start     (cmd_start),
    .cmd_index_out (cmd_index_out),
    .dat_start     (dat_start),
    .dat_dir       (dat_dir),
    .dma_start     (dma_start),
    .cmd_inhibit   (cmd_inhibit),
    .dat_inhibit   (dat_inhibit),
    .blk_remaining (blk_remaining),
    .cmd_complete  (cmd_complete),
    .xfer_complete (xfer_complete),
    .gap_event     (gap_event),
    .err_int       (err_int),
    .err_src       (err_src)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [6:0]  ev;
    logic [5:0]  idx;
    logic [15:0] blk;
    logic [2:0]  err;
    logic        dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void push(input int c, input logic [6:0] ev, input logic [5:0] idx,
                               input logic [15:0] blk, input logic [2:0] err,
                               input logic dir);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    e.idx = idx;
    e.blk = blk;
    e.err = err;
    e.dir = dir;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  logic [6:0] mon_ev;
  exp_t       mon_e;

  always @(negedge CLK) begin
    mon_ev = {err_int, gap_event, xfer_complete, cmd_complete, dma_start, dat_start, cmd_start};
    if (mon_ev !== 7'd0) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_event: got cyc=%0d ev=%b, required no event", cyc, mon_ev);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.cyc || mon_ev !== mon_e.ev || cmd_index_out !== mon_e.idx ||
            blk_remaining !== mon_e.blk || err_src !== mon_e.err || dat_dir !== mon_e.dir) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d ev=%b idx=%0d blk=%0h err=%b dir=%b, %s%0d %s%b %s%0d %s%0h %s%b %s%b",
                   cyc, mon_ev, cmd_index_out, blk_remaining, err_src, dat_dir,
                   "required cyc=", mon_e.cyc, "ev=", mon_e.ev, "idx=", mon_e.idx,
                   "blk=", mon_e.blk, "err=", mon_e.err, "dir=", mon_e.dir);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [5:0] idx, input logic dp, input logic mb, input logic ce,
                     input logic ac, input logic dr, input logic [15:0] bc);
    cmd_index_in = idx;
    data_present = dp;
    multi_blk    = mb;
    blk_cnt_en   = ce;
    auto_cmd12   = ac;
    dir_read     = dr;
    block_count  = bc;
  endtask

  task automatic launch(output int s);
    start_flag = 1'b1;
    s = cyc;
    tick();
    start_flag = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, cmd_start, dat_start, dma_start, cmd_inhibit, dat_inhibit, cmd_complete,
            xfer_complete, gap_event, err_int, dat_dir, cmd_index_out, blk_remaining, err_src};
  endfunction

  int s, d, b, g;

  initial begin
    ticks(2);
    chk("reset_outputs", all_outs(), 64'd0);
    rst_L = 1'b1;
    tick();

    // Non-data command; a second start_flag while busy must be ignored.
    cfg(6'd8, 0, 0, 0, 0, 0, 16'd0);
    launch(s);
    push(s + 1, EvCs, 6'd8, 16'd0, 3'b000, 1'b0);
    chk("nd_cmd_inhibit_busy", cmd_inhibit, 1);
    chk("nd_dat_inhibit", dat_inhibit, 0);
    tick();
    cmd_index_in = 6'd9;
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    cmd_index_in = 6'd8;
    chk("nd_index_held", cmd_index_out, 6'd8);
    ticks(8);
    cmd_done = 1'b1;
    push(cyc + 1, EvCc, 6'd8, 16'd0, 3'b000, 1'b0);
    tick();
    cmd_done = 1'b0;
    ticks(2);
    chk("nd_cmd_inhibit_idle", cmd_inhibit, 0);
    chk("nd_dat_inhibit_idle", dat_inhibit, 0);

    // Single-block read.
    cfg(6'd17, 1, 0, 0, 0, 1, 16'd0);
    launch(s);
    push(s + 1, EvCs, 6'd17, 16'd0, 3'b000, 1'b1);
    chk("sb_dat_inhibit_issue", dat_inhibit, 1);
    tick();
    d = cyc;
    cmd_done = 1'b1;
    push(d + 1, EvCc, 6'd17, 16'd0, 3'b000, 1'b1);
    push(d + 2, EvDs | EvDma, 6'd17, 16'd1, 3'b000, 1'b1);
    tick();
    cmd_done = 1'b0;
    tick();
    chk("sb_cmd_inhibit_xfer", cmd_inhibit, 0);
    chk("sb_dat_dir", dat_dir, 1);
    ticks(2);
    b = cyc;
    dat_blk_done = 1'b1;
    push(b + 1, EvXc, 6'd17, 16'd0, 3'b000, 1'b1);
    tick();
    dat_blk_done = 1'b0;
    tick();
    chk("sb_dat_inhibit_idle", dat_inhibit, 0);

    // Three blocks with Auto CMD12 requested.
    cfg(6'd18, 1, 1, 1, 1, 1, 16'd3);
    launch(s);
    push(s + 1, EvCs, 6'd18, 16'd0, 3'b000, 1'b1);
    tick();
    d = cyc;
    cmd_done = 1'b1;
    push(d + 1, EvCc, 6'd18, 16'd0, 3'b000, 1'b1);
    push(d + 2, EvDs | EvDma, 6'd18, 16'd3, 3'b000, 1'b1);
    tick();
    cmd_done = 1'b0;
    ticks(2);
    for (int k = 0; k < 2; k++) begin
      b = cyc;
      dat_blk_done = 1'b1;
      push(b + 1, EvDs, 6'd18, 16'(2 - k), 3'b000, 1'b1);
      tick();
      dat_blk_done = 1'b0;
      ticks(2);
    end
    b = cyc;
    dat_blk_done = 1'b1;
`ifdef SD_AUTO_CMD12_EN
    push(b + 1, EvCs, 6'd12, 16'd0, 3'b000, 1'b1);
    push(b + 4, EvXc, 6'd18, 16'd0, 3'b000, 1'b1);
`else
    push(b + 1, EvXc, 6'd18, 16'd0, 3'b000, 1'b1);
`endif
    tick();
    dat_blk_done = 1'b0;
    ticks(2);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    ticks(2);

    // Four-block write with a stop at the gap after block two.
    cfg(6'd25, 1, 1, 1, 0, 0, 16'd4);
    launch(s);
    push(s + 1, EvCs, 6'd25, 16'd0, 3'b000, 1'b0);
    tick();
    d = cyc;
    cmd_done = 1'b1;
    push(d + 1, EvCc, 6'd25, 16'd0, 3'b000, 1'b0);
    push(d + 2, EvDs | EvDma, 6'd25, 16'd4, 3'b000, 1'b0);
    tick();
    cmd_done = 1'b0;
    ticks(2);
    b = cyc;
    dat_blk_done = 1'b1;
    push(b + 1, EvDs, 6'd25, 16'd3, 3'b000, 1'b0);
    tick();
    dat_blk_done = 1'b0;
    ticks(2);
    dat_blk_done = 1'b1;
    stop_at_gap = 1'b1;
    push(cyc + 1, EvGap, 6'd25, 16'd2, 3'b000, 1'b0);
    tick();
    dat_blk_done = 1'b0;
    chk("gap_cmd_inhibit", cmd_inhibit, 0);
    chk("gap_dat_inhibit", dat_inhibit, 1);
    continue_req = 1'b1;
    ticks(3);
    chk("gap_blk_held", blk_remaining, 16'd2);
    g = cyc;
    stop_at_gap = 1'b0;
    push(g + 1, EvDs, 6'd25, 16'd2, 3'b000, 1'b0);
    tick();
    continue_req = 1'b0;
    ticks(2);
    dat_blk_done = 1'b1;
    push(cyc + 1, EvDs, 6'd25, 16'd1, 3'b000, 1'b0);
    tick();
    dat_blk_done = 1'b0;
    ticks(2);
    dat_blk_done = 1'b1;
    push(cyc + 1, EvXc, 6'd25, 16'd0, 3'b000, 1'b0);
    tick();
    dat_blk_done = 1'b0;
    tick();

    // DAT error on the final block beats completion.
    cfg(6'd17, 1, 0, 0, 0, 1, 16'd0);
    launch(s);
    push(s + 1, EvCs, 6'd17, 16'd0, 3'b000, 1'b1);
    tick();
    d = cyc;
    cmd_done = 1'b1;
    push(d + 1, EvCc, 6'd17, 16'd0, 3'b000, 1'b1);
    push(d + 2, EvDs | EvDma, 6'd17, 16'd1, 3'b000, 1'b1);
    tick();
    cmd_done = 1'b0;
    ticks(2);
    dat_blk_done = 1'b1;
    dat_err = 1'b1;
    push(cyc + 1, EvErr, 6'd17, 16'd1, 3'b010, 1'b1);
    tick();
    dat_blk_done = 1'b0;
    dat_err = 1'b0;
    chk("err_dat_inhibit_drop", dat_inhibit, 0);
    tick();
    chk("err_src_latched", err_src, 3'b010);

    // cmd_err together with cmd_done.
    cfg(6'd8, 0, 0, 0, 0, 0, 16'd0);
    launch(s);
    push(s + 1, EvCs, 6'd8, 16'd0, 3'b000, 1'b0);
    tick();
    cmd_done = 1'b1;
    cmd_err = 1'b1;
    push(cyc + 1, EvErr, 6'd8, 16'd0, 3'b001, 1'b0);
    tick();
    cmd_done = 1'b0;
    cmd_err = 1'b0;
    tick();

    // Infinite multi-block transfer ended by an ADMA error.
    cfg(6'd18, 1, 1, 0, 0, 1, 16'd7);
    launch(s);
    push(s + 1, EvCs, 6'd18, 16'd0, 3'b000, 1'b1);
    tick();
    d = cyc;
    cmd_done = 1'b1;
    push(d + 1, EvCc, 6'd18, 16'd0, 3'b000, 1'b1);
    push(d + 2, EvDs | EvDma, 6'd18, 16'hFFFF, 3'b000, 1'b1);
    tick();
    cmd_done = 1'b0;
    ticks(2);
    dat_blk_done = 1'b1;
    push(cyc + 1, EvDs, 6'd18, 16'hFFFF, 3'b000, 1'b1);
    tick();
    dat_blk_done = 1'b0;
    ticks(2);
    dma_err = 1'b1;
    push(cyc + 1, EvErr, 6'd18, 16'hFFFF, 3'b100, 1'b1);
    tick();
    dma_err = 1'b0;
    tick();

    // Asynchronous reset in the middle of a transfer.
    cfg(6'd18, 1, 1, 1, 0, 0, 16'd5);
    launch(s);
    push(s + 1, EvCs, 6'd18, 16'd0, 3'b000, 1'b0);
    tick();
    d = cyc;
    cmd_done = 1'b1;
    push(d + 1, EvCc, 6'd18, 16'd0, 3'b000, 1'b0);
    push(d + 2, EvDs | EvDma, 6'd18, 16'd5, 3'b000, 1'b0);
    tick();
    cmd_done = 1'b0;
    ticks(2);
    chk("pre_reset_blk", blk_remaining, 16'd5);
    #2;
    rst_L = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    ticks(2);
    #2;
    rst_L = 1'b1;
    tick();

    // Zero block count with counting enabled finishes without data pulses.
    cfg(6'd18, 1, 1, 1, 0, 0, 16'd0);
    launch(s);
    push(s + 1, EvCs, 6'd18, 16'd0, 3'b000, 1'b0);
    tick();
    d = cyc;
    cmd_done = 1'b1;
    push(d + 1, EvCc, 6'd18, 16'd0, 3'b000, 1'b0);
    push(d + 2, EvXc, 6'd18, 16'd0, 3'b000, 1'b0);
    tick();
    cmd_done = 1'b0;
    ticks(2);
    chk("zero_cnt_dat_inhibit", dat_inhibit, 0);
    chk("zero_cnt_blk", blk_remaining, 16'd0);

    ticks(3);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_event: got none, required cyc=%0d ev=%b", mon_e.cyc, mon_e.ev);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
